// File: rtl/gpp_net_interface.sv
// gpp_net_interface: processor-side network interface stage.
// TX requests become header+payload flits; inbound packets fill an RX FIFO.
module gpp_net_interface #(
  parameter logic [3:0] NODE_ID  = 4'd0,
  parameter int         TX_DEPTH = 4,
  parameter int         RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_req,
  input  logic [3:0]  tx_dst,
  input  logic [15:0] tx_data,
  output logic        tx_full,
  output logic        tx_overflow,
  output logic        rx_avail,
  input  logic        rx_pop,
  output logic [3:0]  rx_src,
  output logic [15:0] rx_data,
  output logic        link_tx_valid,
  output logic [15:0] link_tx_flit,
  input  logic        link_tx_ready,
  input  logic        link_rx_valid,
  input  logic [15:0] link_rx_flit,
  output logic        link_rx_ready,
  output logic [7:0]  drop_count,
  output logic        busy
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam logic [3:0] MARK = 4'b1010;

  typedef enum logic [1:0] {T_IDLE, T_HDR, T_PAY} tx_st_e;
  typedef enum logic {R_HDR, R_PAY} rx_st_e;

  tx_st_e tx_st_q;
  rx_st_e rx_st_q;

  logic [19:0]    tx_mem_q [TX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_rp_q;
  logic [TAW:0]   tx_cnt_q, tx_cnt_d;
  logic           tx_ovf_q;
  logic           tx_push, tx_pop;
  logic [19:0]    tx_head;

  logic [19:0]    rx_mem_q [RX_DEPTH];
  logic [RAW-1:0] rx_wp_q, rx_rp_q;
  logic [RAW:0]   rx_cnt_q, rx_cnt_d;
  logic           rx_full, rx_acc, rx_push, rx_pop_ok, rx_drop;
  logic [3:0]     rx_src_q;
  logic           match_q;
  logic [7:0]     drop_q;

  assign tx_full  = (tx_cnt_q == (TAW+1)'(TX_DEPTH));
  assign tx_push  = tx_req && !tx_full;
  assign tx_pop   = (tx_st_q == T_PAY) && link_tx_ready;
  assign tx_head  = tx_mem_q[tx_rp_q];

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)
      tx_cnt_d = tx_cnt_q + (TAW+1)'(1);
    else if (tx_pop && !tx_push)
      tx_cnt_d = tx_cnt_q - (TAW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= {tx_dst, tx_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
      tx_ovf_q <= 1'b0;
      tx_st_q  <= T_IDLE;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + TAW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + TAW'(1);
      tx_cnt_q <= tx_cnt_d;
      if (tx_req && tx_full) tx_ovf_q <= 1'b1;
      unique case (tx_st_q)
        T_IDLE: if (tx_cnt_q != '0) tx_st_q <= T_HDR;
        T_HDR:  if (link_tx_ready) tx_st_q <= T_PAY;
        T_PAY:  if (link_tx_ready)
                  tx_st_q <= (tx_cnt_d != '0) ? T_HDR : T_IDLE;
        default: tx_st_q <= T_IDLE;
      endcase
    end
  end

  // Flit is a pure function of state and FIFO head, so it holds under stall.
  always_comb begin
    link_tx_flit = '0;
    unique case (1'b1)
      (tx_st_q == T_HDR): link_tx_flit = {MARK, NODE_ID, tx_head[19:16], 4'h0};
      (tx_st_q == T_PAY): link_tx_flit = tx_head[15:0];
      default:            link_tx_flit = '0;
    endcase
  end

  assign link_tx_valid = (tx_st_q != T_IDLE);
  assign tx_overflow   = tx_ovf_q;
  assign busy          = (tx_cnt_q != '0) || (tx_st_q != T_IDLE);

  assign rx_full       = (rx_cnt_q == (RAW+1)'(RX_DEPTH));
  assign link_rx_ready = (rx_st_q == R_HDR) || !match_q || !rx_full;
  assign rx_acc        = link_rx_valid && link_rx_ready;
  assign rx_push       = rx_acc && (rx_st_q == R_PAY) && match_q;
  assign rx_pop_ok     = rx_pop && (rx_cnt_q != '0);
  assign rx_drop       = rx_acc &&
                         (((rx_st_q == R_HDR) && (link_rx_flit[15:12] != MARK)) ||
                          ((rx_st_q == R_PAY) && !match_q));

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop_ok)
      rx_cnt_d = rx_cnt_q + (RAW+1)'(1);
    else if (rx_pop_ok && !rx_push)
      rx_cnt_d = rx_cnt_q - (RAW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wp_q] <= {rx_src_q, link_rx_flit};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      rx_st_q  <= R_HDR;
      rx_src_q <= '0;
      match_q  <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (rx_push)   rx_wp_q <= rx_wp_q + RAW'(1);
      if (rx_pop_ok) rx_rp_q <= rx_rp_q + RAW'(1);
      rx_cnt_q <= rx_cnt_d;
      if (rx_drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      unique case (rx_st_q)
        R_HDR: if (rx_acc && link_rx_flit[15:12] == MARK) begin
                 rx_src_q <= link_rx_flit[11:8];
                 match_q  <= (link_rx_flit[7:4] == NODE_ID);
                 rx_st_q  <= R_PAY;
               end
        R_PAY: if (rx_acc) rx_st_q <= R_HDR;
        default: rx_st_q <= R_HDR;
      endcase
    end
  end

  assign rx_avail   = (rx_cnt_q != '0);
  assign rx_src     = rx_avail ? rx_mem_q[rx_rp_q][19:16] : '0;
  assign rx_data    = rx_avail ? rx_mem_q[rx_rp_q][15:0] : '0;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_gpp_net_interface.sv
// tb_gpp_net_interface: directed checks of gpp_net_interface, NODE_ID=2.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_gpp_net_interface;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tx_req = 1'b0;
  logic [3:0]  tx_dst = '0;
  logic [15:0] tx_data = '0;
  logic        tx_full, tx_overflow, rx_avail;
  logic        rx_pop = 1'b0;
  logic [3:0]  rx_src;
  logic [15:0] rx_data;
  logic        link_tx_valid;
  logic [15:0] link_tx_flit;
  logic        link_tx_ready = 1'b1;
  logic        link_rx_valid = 1'b0;
  logic [15:0] link_rx_flit = '0;
  logic        link_rx_ready;
  logic [7:0]  drop_count;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int nfl;
  logic [15:0] fl [8];

  gpp_net_interface #(.NODE_ID(4'd2), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .tx_req(tx_req), .tx_dst(tx_dst), .tx_data(tx_data),
    .tx_full(tx_full), .tx_overflow(tx_overflow),
    .rx_avail(rx_avail), .rx_pop(rx_pop),
    .rx_src(rx_src), .rx_data(rx_data),
    .link_tx_valid(link_tx_valid), .link_tx_flit(link_tx_flit),
    .link_tx_ready(link_tx_ready),
    .link_rx_valid(link_rx_valid), .link_rx_flit(link_rx_flit),
    .link_rx_ready(link_rx_ready),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_tx_full"},  32'(tx_full), 32'd0);
    chk({pfx, "_tx_ovf"},   32'(tx_overflow), 32'd0);
    chk({pfx, "_rx_avail"}, 32'(rx_avail), 32'd0);
    chk({pfx, "_rx_src"},   32'(rx_src), 32'd0);
    chk({pfx, "_rx_data"},  32'(rx_data), 32'd0);
    chk({pfx, "_tx_valid"}, 32'(link_tx_valid), 32'd0);
    chk({pfx, "_tx_flit"},  32'(link_tx_flit), 32'd0);
    chk({pfx, "_rx_ready"}, 32'(link_rx_ready), 32'd1);
    chk({pfx, "_drops"},    32'(drop_count), 32'd0);
    chk({pfx, "_busy"},     32'(busy), 32'd0);
  endtask

  task automatic push_tx(input logic [3:0] d, input logic [15:0] w);
    tx_req = 1'b1; tx_dst = d; tx_data = w;
    tick();
    tx_req = 1'b0;
  endtask

  task automatic send_rx(input logic [15:0] f);
    link_rx_valid = 1'b1; link_rx_flit = f;
    tick();
    link_rx_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b1;
    chk_reset("rst");

    // single packet: request at cycle 0
    push_tx(4'd5, 16'h1234);
    chk("t1_c1_valid", 32'(link_tx_valid), 32'd0);
    tick();
    chk("t1_c2_valid", 32'(link_tx_valid), 32'd1);
    chk("t1_c2_hdr", 32'(link_tx_flit), 32'h0000A250);
    tick();
    chk("t1_c3_pay", 32'(link_tx_flit), 32'h00001234);
    tick();
    chk("t1_c4_busy", 32'(busy), 32'd0);
    chk("t1_c4_valid", 32'(link_tx_valid), 32'd0);

    // header backpressure for 3 cycles
    link_tx_ready = 1'b0;
    push_tx(4'd5, 16'h5678);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("t2_stall_valid", 32'(link_tx_valid), 32'd1);
      chk("t2_stall_hdr", 32'(link_tx_flit), 32'h0000A250);
      tick();
    end
    chk("t2_last_hdr", 32'(link_tx_flit), 32'h0000A250);
    link_tx_ready = 1'b1;
    tick();
    chk("t2_pay", 32'(link_tx_flit), 32'h00005678);
    tick();
    chk("t2_done", 32'(link_tx_valid), 32'd0);

    // fill TX FIFO past capacity with link stalled
    link_tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_req = 1'b1; tx_dst = 4'(i); tx_data = 16'h1000 + 16'(i);
      tick();
    end
    tx_req = 1'b0;
    chk("t3_full", 32'(tx_full), 32'd1);
    chk("t3_ovf", 32'(tx_overflow), 32'd1);
    link_tx_ready = 1'b1;
    nfl = 0;
    for (int c = 0; c < 20; c++) begin
      if (link_tx_valid) begin
        if (nfl < 8) fl[nfl] = link_tx_flit;
        nfl++;
      end
      tick();
    end
    chk("t3_nflits", 32'(nfl), 32'd8);
    chk("t3_fl0", 32'(fl[0]), 32'h0000A200);
    chk("t3_fl1", 32'(fl[1]), 32'h00001000);
    chk("t3_fl6", 32'(fl[6]), 32'h0000A230);
    chk("t3_fl7", 32'(fl[7]), 32'h00001003);
    chk("t3_not_full", 32'(tx_full), 32'd0);
    chk("t3_ovf_sticky", 32'(tx_overflow), 32'd1);

    // RX accept and pop
    send_rx(16'hA720);
    send_rx(16'hBEEF);
    chk("t4_avail", 32'(rx_avail), 32'd1);
    chk("t4_src", 32'(rx_src), 32'd7);
    chk("t4_data", 32'(rx_data), 32'h0000BEEF);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    chk("t4_popped", 32'(rx_avail), 32'd0);

    // RX drops: foreign destination, then bad marker
    send_rx(16'hA730);
    send_rx(16'h5555);
    chk("t5_drop1", 32'(drop_count), 32'd1);
    chk("t5_nopush", 32'(rx_avail), 32'd0);
    send_rx(16'h1234);
    chk("t5_drop2", 32'(drop_count), 32'd2);
    chk("t5_rhdr_ready", 32'(link_rx_ready), 32'd1);

    // RX full: four packets, fifth stalls in payload
    for (int i = 0; i < 4; i++) begin
      send_rx(16'hA020 | 16'((i + 1) << 8));
      send_rx(16'h0100 + 16'(i));
    end
    chk("t6_avail", 32'(rx_avail), 32'd1);
    chk("t6_head_src", 32'(rx_src), 32'd1);
    send_rx(16'hA520);
    link_rx_valid = 1'b1; link_rx_flit = 16'h0555;
    chk("t6_stall0", 32'(link_rx_ready), 32'd0);
    tick();
    chk("t6_stall1", 32'(link_rx_ready), 32'd0);
    rx_pop = 1'b1;
    tick();
    rx_pop = 1'b0;
    chk("t6_ready", 32'(link_rx_ready), 32'd1);
    chk("t6_src2", 32'(rx_src), 32'd2);
    tick();
    link_rx_valid = 1'b0;
    chk("t6_data2", 32'(rx_data), 32'h00000101);
    chk("t6_drops", 32'(drop_count), 32'd2);
    chk("t6_back_hdr", 32'(link_rx_ready), 32'd1);

    // reset while a TX header is stalled
    link_tx_ready = 1'b0;
    push_tx(4'd9, 16'hCAFE);
    tick();
    chk("t7_hdr", 32'(link_tx_flit), 32'h0000A290);
    chk("t7_ovf_held", 32'(tx_overflow), 32'd1);
    rst = 1'b0;
    tick();
    chk_reset("midrst");
    rst = 1'b1;
    link_tx_ready = 1'b1;
    tick(); tick();
    chk("t7_quiet", 32'(link_tx_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpp_net_interface.md
Name: gpp_net_interface

Overview:
- Network interface stage directly downstream of the general-purpose processor.
- Consumes the processor's data-transfer requests (the gpp_trf_dp path) and buffers them in a TX FIFO.
- Frames each request as a two-flit packet (header, payload) and drives it onto the 16-bit interconnect link with a valid/ready handshake.
- Reassembles inbound packets addressed to this node into an RX FIFO that the processor pops.

Parameters:
NODE_ID, 0, 4-bit identifier of this node; used as source in TX headers and as destination match on RX.
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2).
RX_DEPTH, 4, RX FIFO entries (power of 2, >=2).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (rst==0 at a rising edge resets)
tx_req  input  1  processor transfer strobe, one entry per cycle high
tx_dst  input  4  destination node of the transfer
tx_data  input  16  payload word
tx_full  output  1  TX FIFO full
tx_overflow  output  1  sticky: tx_req arrived while tx_full
rx_avail  output  1  RX FIFO non-empty
rx_pop  input  1  processor consumes head RX entry
rx_src  output  4  source node of head RX entry (first-word fall-through)
rx_data  output  16  payload of head RX entry
link_tx_valid  output  1  outbound flit valid
link_tx_flit  output  16  outbound flit
link_tx_ready  input  1  link accepts outbound flit
link_rx_valid  input  1  inbound flit valid
link_rx_flit  input  16  inbound flit
link_rx_ready  output  1  interface accepts inbound flit
drop_count  output  8  saturating count of discarded inbound packets/flits
busy  output  1  TX FIFO non-empty or TX FSM not idle

Behaviour:
- Reset values: all FIFOs empty; TX FSM = T_IDLE; RX FSM = R_HDR; tx_full=0, tx_overflow=0, rx_avail=0, rx_src=0, rx_data=0, link_tx_valid=0, link_tx_flit=0, link_rx_ready=1, drop_count=0, busy=0.
- Reset mid-packet: partial TX and RX packets are discarded with no further flits emitted. link_tx_valid is 0 in the cycle after reset is sampled.
- Header format: [15:12]=4'b1010 marker, [11:8]=src, [7:4]=dst, [3:0]=0. Payload flit = data word.
- TX push: on tx_req && !tx_full, store {tx_dst, tx_data}.
- TX overflow: tx_req while full is dropped and sets tx_overflow, which stays set until reset.
- TX FSM states:
  - T_IDLE: if FIFO non-empty, go to T_HDR.
  - T_HDR: link_tx_valid=1, flit = header of head entry. On link_tx_ready, go to T_PAY.
  - T_PAY: link_tx_valid=1, flit = head payload. On link_tx_ready, pop FIFO; go to T_HDR if entries remain after the pop, else T_IDLE.
- TX latency: tx_req at cycle N into an empty idle interface gives the header valid at N+2 and the payload no earlier than N+3. Back-to-back packets have no idle gap.
- Handshake: a transfer occurs on a cycle with valid&&ready. link_tx_valid/link_tx_flit stay stable while valid&&!ready; valid never drops without a transfer.
- TX simultaneity: push and pop in the same cycle are allowed. tx_full reflects the registered occupancy.
- RX FSM states:
  - R_HDR: link_rx_ready=1. On an accepted flit with marker != 4'b1010, discard it, increment drop_count, stay in R_HDR. With a valid marker, latch src and match = (dst==NODE_ID), then go to R_PAY.
  - R_PAY: link_rx_ready = !match || !rx_full. On an accepted flit: if match, push {src, flit}; else increment drop_count. Return to R_HDR.
- drop_count saturates at 255.
- RX pop: rx_pop with rx_avail=1 removes the head; rx_pop when empty is ignored. Push and pop in the same cycle are allowed.
- RX full: no bypass when full. The payload is stalled until space frees, and the FSM remains in R_PAY.
- rx_avail latency: rx_avail rises the cycle after the payload push.
- busy = FIFO non-empty or TX FSM != T_IDLE.

Test Plan:
- Single packet, NODE_ID=2, link_tx_ready=1: tx_req at cycle 0 with dst=5, data=16'h1234 -> header 16'hA250 at cycle 2, payload 16'h1234 at cycle 3, busy low at cycle 4.
- Backpressure: hold link_tx_ready=0 for 3 cycles during the header -> flit stays 16'hA250 and valid stays 1; header then payload complete after ready rises.
- TX fill: 5 consecutive tx_req with TX_DEPTH=4 and link_tx_ready=0 -> tx_full=1 after 4 pushes, tx_overflow=1, only 4 packets emitted once ready rises.
- RX accept, NODE_ID=2: inbound 16'hA720 then 16'hBEEF -> rx_avail=1, rx_src=7, rx_data=16'hBEEF; rx_pop -> rx_avail=0.
- RX drops: inbound 16'hA730 + payload (dst=3) -> drop_count=1 and no push. Inbound 16'h1234 (bad marker) -> drop_count=2 and FSM stays in R_HDR.
- RX full plus reset: fill 4 entries, send a fifth matching packet -> link_rx_ready=0 in R_PAY. Pop once -> payload accepted. Then assert rst=0 mid-TX-packet -> all outputs at reset values next cycle.
